decode_execute_pipe: RTL and testbench

Two-stage, parametrised successor to the single-cycle decode/execute block. It accepts one fixed-format 32-bit instruction per cycle over a valid/ready handshake. Stage 1 decodes and reads an internal register file; stage 2 executes and writes back. Forwarding resolves back-to-back dependencies. The block sits between instruction fetch and the writeback/commit logic, and reports a registered result, write-enable, destination and illegal-opcode flag.

---
 rtl/decode_execute_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_decode_execute_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute pipe with forwarding; optional iterative MUL (DECODE_EXECUTE_MUL_EN).
// Latency: 2 cycles issue-to-result (XLEN+1 for MUL); throughput 1/cycle in RUN.
// Backpressure: in_ready drops only while a MUL iterates; stage 1 holds its instruction then.
module decode_execute_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            reg_write_enable,
    output logic [3:0]      wb_addr,
    output logic            illegal
);
    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LUI  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;

`ifdef DECODE_EXECUTE_MUL_EN
    localparam logic [3:0]     OP_MUL   = 4'hC;
    localparam logic [SHW-1:0] MUL_LAST = SHW'(XLEN - 2);
    typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;
`else
    typedef enum logic {RUN = 1'b0} state_t;
`endif

    state_t state, state_nxt;

    logic            s1_vld;
    logic [31:0]     s1_ins;
    logic            s2_vld;
    logic [3:0]      s2_op;
    logic [3:0]      s2_rd;
    logic [XLEN-1:0] s2_a;
    logic [XLEN-1:0] s2_b;
    logic [15:0]     s2_imm;

    logic [XLEN-1:0] rf [NREGS];

    logic [3:0]      s1_op;
    logic [AW-1:0]   s1_rs1, s1_rs2, s2_rd_idx;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] ex_res, imm_sx, lui_v;
    logic [SHW-1:0]  shamt;
    logic            ex_wr, ex_we, ex_ill, fwd_en, adv;

    assign s1_op     = s1_ins[31:28];
    assign s1_rs1    = s1_ins[20 +: AW];
    assign s1_rs2    = s1_ins[16 +: AW];
    assign s2_rd_idx = s2_rd[AW-1:0];
    assign imm_sx    = XLEN'($signed(s2_imm));
    assign lui_v     = XLEN'({s2_imm, 16'h0000});
    assign shamt     = s2_b[SHW-1:0];
    assign adv       = (state == RUN);

`ifdef DECODE_EXECUTE_MUL_EN
    logic [XLEN-1:0] mul_acc, mul_sum;
    logic [SHW-1:0]  mul_cnt;
    assign mul_sum = mul_acc + (s2_b[0] ? s2_a : '0);
    // A MUL value is only final in its completion cycle, which is the RUN cycle it sits in stage 2.
    assign fwd_en  = s2_vld && ex_we && (state == RUN);
`else
    assign fwd_en  = s2_vld && ex_we;
`endif

    always_comb begin
        ex_res = '0;
        ex_wr  = 1'b0;
        ex_ill = 1'b0;
        case (s2_op)
            OP_NOP:  ;
            OP_ADD:  begin ex_res = s2_a + s2_b;             ex_wr = 1'b1; end
            OP_SUB:  begin ex_res = s2_a - s2_b;             ex_wr = 1'b1; end
            OP_AND:  begin ex_res = s2_a & s2_b;             ex_wr = 1'b1; end
            OP_OR:   begin ex_res = s2_a | s2_b;             ex_wr = 1'b1; end
            OP_XOR:  begin ex_res = s2_a ^ s2_b;             ex_wr = 1'b1; end
            OP_SLL:  begin ex_res = s2_a << shamt;           ex_wr = 1'b1; end
            OP_SRL:  begin ex_res = s2_a >> shamt;           ex_wr = 1'b1; end
            OP_SRA:  begin ex_res = $signed(s2_a) >>> shamt; ex_wr = 1'b1; end
            OP_ADDI: begin ex_res = s2_a + imm_sx;           ex_wr = 1'b1; end
            OP_LUI:  begin ex_res = lui_v;                   ex_wr = 1'b1; end
            OP_SLT:  begin ex_res[0] = $signed(s2_a) < $signed(s2_b); ex_wr = 1'b1; end
`ifdef DECODE_EXECUTE_MUL_EN
            OP_MUL:  begin ex_res = mul_sum;                 ex_wr = 1'b1; end
`endif
            default: ex_ill = 1'b1;
        endcase
    end

    assign ex_we = ex_wr && (s2_rd_idx != '0);

    always_comb begin
        if (s1_rs1 == '0)
            rs1_val = '0;
        else if (fwd_en && (s2_rd_idx == s1_rs1))
            rs1_val = ex_res;
        else
            rs1_val = rf[s1_rs1];
    end

    always_comb begin
        if (s1_rs2 == '0)
            rs2_val = '0;
        else if (fwd_en && (s2_rd_idx == s1_rs2))
            rs2_val = ex_res;
        else
            rs2_val = rf[s1_rs2];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef DECODE_EXECUTE_MUL_EN
        case (state)
            RUN:      if (s1_vld && (s1_op == OP_MUL)) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_cnt == MUL_LAST)         state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
`endif
    end

    always_comb begin
        in_ready = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld           <= 1'b0;
            s1_ins           <= '0;
            s2_vld           <= 1'b0;
            s2_op            <= '0;
            s2_rd            <= '0;
            s2_a             <= '0;
            s2_b             <= '0;
            s2_imm           <= '0;
            result           <= '0;
            result_valid     <= 1'b0;
            reg_write_enable <= 1'b0;
            wb_addr          <= '0;
            illegal          <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
`ifdef DECODE_EXECUTE_MUL_EN
            mul_acc          <= '0;
            mul_cnt          <= '0;
`endif
        end else if (adv) begin
            s1_vld <= in_valid;
            if (in_valid) s1_ins <= instruction;
            s2_vld <= s1_vld;
            s2_op  <= s1_op;
            s2_rd  <= s1_ins[27:24];
            s2_a   <= rs1_val;
            s2_b   <= rs2_val;
            s2_imm <= s1_ins[15:0];
            result_valid     <= s2_vld;
            result           <= s2_vld ? ex_res : '0;
            reg_write_enable <= s2_vld && ex_we;
            wb_addr          <= s2_vld ? s2_rd : '0;
            illegal          <= s2_vld && ex_ill;
            if (s2_vld && ex_we) rf[s2_rd_idx] <= ex_res;
`ifdef DECODE_EXECUTE_MUL_EN
            mul_acc <= '0;
            mul_cnt <= '0;
`endif
        end else begin
            result_valid     <= 1'b0;
            result           <= '0;
            reg_write_enable <= 1'b0;
            wb_addr          <= '0;
            illegal          <= 1'b0;
`ifdef DECODE_EXECUTE_MUL_EN
            // Shift-add: the operand registers double as the multiplicand/multiplier shifters.
            mul_acc <= mul_sum;
            s2_a    <= s2_a << 1;
            s2_b    <= s2_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe: vector table plus multi-cycle MUL and reset sequences.
module tb_decode_execute_pipe;
    localparam int XLEN = 32;
    localparam int N    = 22;

`ifdef DECODE_EXECUTE_MUL_EN
    localparam int          L       = XLEN;
    localparam logic [31:0] MUL_RES = 32'hFFFF_FFFD;
    localparam logic        MUL_ILL = 1'b0;
    localparam logic        MUL_WE  = 1'b1;
`else
    localparam int          L       = 1;
    localparam logic [31:0] MUL_RES = 32'h0;
    localparam logic        MUL_ILL = 1'b1;
    localparam logic        MUL_WE  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            reg_write_enable;
    logic [3:0]      wb_addr;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    decode_execute_pipe #(.XLEN(XLEN), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .result(result), .result_valid(result_valid),
        .reg_write_enable(reg_write_enable), .wb_addr(wb_addr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic        we;
        logic [3:0]  wb;
        logic        ill;
    } vec_t;

    vec_t vt [N];

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid    = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic expect_retire(input string nm, input logic [31:0] r, input logic we,
                                 input logic [3:0] wb, input logic il);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!result_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_seen"}, 64'(result_valid), 64'd1);
        chk({nm, "_res"},  64'(result), 64'(r));
        chk({nm, "_we"},   64'(reg_write_enable), 64'(we));
        chk({nm, "_wb"},   64'(wb_addr), 64'(wb));
        chk({nm, "_ill"},  64'(illegal), 64'(il));
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_vld"}, 64'(result_valid), 64'd0);
        chk({nm, "_res"}, 64'(result), 64'd0);
        chk({nm, "_we"},  64'(reg_write_enable), 64'd0);
        chk({nm, "_wb"},  64'(wb_addr), 64'd0);
        chk({nm, "_ill"}, 64'(illegal), 64'd0);
        chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int low, acc_c, nret, cnt;
        int          ret_c  [3];
        logic [31:0] ret_r  [3];
        logic [3:0]  ret_wb [3];
        logic        ret_we [3];
        logic        ret_il [3];
        logic        rdy;

        vt[0]  = '{mk(4'h9, 4'd1,  4'd0, 4'd0, 16'd5),    32'h0000_0005, 1'b1, 4'd1,  1'b0};
        vt[1]  = '{mk(4'h9, 4'd2,  4'd0, 4'd0, 16'hFFFD), 32'hFFFF_FFFD, 1'b1, 4'd2,  1'b0};
        vt[2]  = '{mk(4'h9, 4'd1,  4'd0, 4'd0, 16'd7),    32'h0000_0007, 1'b1, 4'd1,  1'b0};
        vt[3]  = '{mk(4'h1, 4'd2,  4'd1, 4'd1, 16'd0),    32'h0000_000E, 1'b1, 4'd2,  1'b0};
        vt[4]  = '{mk(4'h2, 4'd3,  4'd2, 4'd1, 16'd0),    32'h0000_0007, 1'b1, 4'd3,  1'b0};
        vt[5]  = '{mk(4'hA, 4'd1,  4'd0, 4'd0, 16'h8000), 32'h8000_0000, 1'b1, 4'd1,  1'b0};
        vt[6]  = '{mk(4'h9, 4'd2,  4'd0, 4'd0, 16'd4),    32'h0000_0004, 1'b1, 4'd2,  1'b0};
        vt[7]  = '{mk(4'h6, 4'd5,  4'd1, 4'd2, 16'd0),    32'h0000_0000, 1'b1, 4'd5,  1'b0};
        vt[8]  = '{mk(4'h7, 4'd6,  4'd1, 4'd2, 16'd0),    32'h0800_0000, 1'b1, 4'd6,  1'b0};
        vt[9]  = '{mk(4'h8, 4'd7,  4'd1, 4'd2, 16'd0),    32'hF800_0000, 1'b1, 4'd7,  1'b0};
        vt[10] = '{mk(4'hB, 4'd8,  4'd1, 4'd2, 16'd0),    32'h0000_0001, 1'b1, 4'd8,  1'b0};
        vt[11] = '{mk(4'hB, 4'd8,  4'd2, 4'd1, 16'd0),    32'h0000_0000, 1'b1, 4'd8,  1'b0};
        vt[12] = '{mk(4'h3, 4'd9,  4'd2, 4'd3, 16'd0),    32'h0000_0004, 1'b1, 4'd9,  1'b0};
        vt[13] = '{mk(4'h4, 4'd9,  4'd1, 4'd3, 16'd0),    32'h8000_0007, 1'b1, 4'd9,  1'b0};
        vt[14] = '{mk(4'h5, 4'd10, 4'd2, 4'd3, 16'd0),    32'h0000_0003, 1'b1, 4'd10, 1'b0};
        vt[15] = '{mk(4'hE, 4'd3,  4'd1, 4'd2, 16'd0),    32'h0000_0000, 1'b0, 4'd3,  1'b1};
        vt[16] = '{mk(4'h9, 4'd0,  4'd0, 4'd0, 16'd9),    32'h0000_0009, 1'b0, 4'd0,  1'b0};
        vt[17] = '{mk(4'h1, 4'd11, 4'd0, 4'd3, 16'd0),    32'h0000_0007, 1'b1, 4'd11, 1'b0};
        vt[18] = '{mk(4'h0, 4'd0,  4'd0, 4'd0, 16'd0),    32'h0000_0000, 1'b0, 4'd0,  1'b0};
        vt[19] = '{mk(4'h1, 4'd12, 4'd5, 4'd6, 16'd0),    32'h0800_0000, 1'b1, 4'd12, 1'b0};
        vt[20] = '{mk(4'h1, 4'd13, 4'd1, 4'd1, 16'd0),    32'h0000_0000, 1'b1, 4'd13, 1'b0};
        vt[21] = '{mk(4'h2, 4'd14, 4'd0, 4'd2, 16'd0),    32'hFFFF_FFFC, 1'b1, 4'd14, 1'b0};

        reset = 1'b1; in_valid = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Back-to-back stream: vector k retires two edges after it is presented.
        for (int k = 0; k < N + 3; k++) begin
            if (k < N) begin
                in_valid = 1'b1; instruction = vt[k].ins;
            end else begin
                in_valid = 1'b0;
            end
            chk($sformatf("vec%0d_rdy", k), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (k >= 2 && k - 2 < N) begin
                chk($sformatf("vec%0d_vld", k - 2), 64'(result_valid), 64'd1);
                chk($sformatf("vec%0d_res", k - 2), 64'(result), 64'(vt[k-2].res));
                chk($sformatf("vec%0d_we",  k - 2), 64'(reg_write_enable), 64'(vt[k-2].we));
                chk($sformatf("vec%0d_wb",  k - 2), 64'(wb_addr), 64'(vt[k-2].wb));
                chk($sformatf("vec%0d_ill", k - 2), 64'(illegal), 64'(vt[k-2].ill));
            end else begin
                chk($sformatf("bubble%0d_vld", k), 64'(result_valid), 64'd0);
            end
        end

        // Dependent instruction two edges later reads the register file.
        issue(mk(4'h9, 4'd1, 4'd0, 4'd0, 16'd3));
        @(posedge clk); #1;
        issue(mk(4'h1, 4'd2, 4'd1, 4'd1, 16'd0));
        chk("gap_addi_vld", 64'(result_valid), 64'd1);
        chk("gap_addi_res", 64'(result), 64'd3);
        expect_retire("gap_add", 32'd6, 1'b1, 4'd2, 1'b0);
        issue(mk(4'h9, 4'd2, 4'd0, 4'd0, 16'hFFFF));
        expect_retire("set_r2", 32'hFFFF_FFFF, 1'b1, 4'd2, 1'b0);

        // MUL r4,r1,r2 followed by ADD r5,r4,r0 and ADDI r6,r0,1.
        in_valid = 1'b1; instruction = mk(4'hC, 4'd4, 4'd1, 4'd2, 16'd0);
        @(posedge clk); #1;
        chk("mul_rdy_issue", 64'(in_ready), 64'd1);
        instruction = mk(4'h1, 4'd5, 4'd4, 4'd0, 16'd0);
        @(posedge clk); #1;
        instruction = mk(4'h9, 4'd6, 4'd0, 4'd0, 16'd1);
        low = 0; acc_c = -1; nret = 0;
        for (int c = 1; c <= 40; c++) begin
            rdy = in_ready;
            if (!rdy) low++;
            @(posedge clk); #1;
            if (rdy && in_valid) begin
                acc_c = c; in_valid = 1'b0;
            end
            if (result_valid) begin
                if (nret < 3) begin
                    ret_c[nret] = c; ret_r[nret] = result; ret_wb[nret] = wb_addr;
                    ret_we[nret] = reg_write_enable; ret_il[nret] = illegal;
                end
                nret++;
            end
        end
        chk("mul_nret", 64'(nret), 64'd3);
        if (nret >= 3) begin
            chk("mul_edge",  64'(ret_c[0]), 64'(L));
            chk("mul_res",   64'(ret_r[0]), 64'(MUL_RES));
            chk("mul_ill",   64'(ret_il[0]), 64'(MUL_ILL));
            chk("mul_we",    64'(ret_we[0]), 64'(MUL_WE));
            chk("mul_wb",    64'(ret_wb[0]), 64'd4);
            chk("dep_edge",  64'(ret_c[1]), 64'(L + 1));
            chk("dep_res",   64'(ret_r[1]), 64'(MUL_RES));
            chk("dep_wb",    64'(ret_wb[1]), 64'd5);
            chk("dep_we",    64'(ret_we[1]), 64'd1);
            chk("next_edge", 64'(ret_c[2]), 64'(L + 2));
            chk("next_res",  64'(ret_r[2]), 64'd1);
            chk("next_wb",   64'(ret_wb[2]), 64'd6);
        end
        chk("mul_accept_edge", 64'(acc_c), 64'(L));
        chk("mul_rdy_low",     64'(low), 64'(L - 1));

        // Reset with two instructions in flight.
        in_valid = 1'b1; instruction = mk(4'h9, 4'd7, 4'd0, 4'd0, 16'h0055);
        @(posedge clk); #1;
        instruction = mk(4'h9, 4'd8, 4'd0, 4'd0, 16'h0066);
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle_outputs("rst_flight");
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_flight_rdy%0d", c), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (result_valid) cnt++;
        end
        chk("rst_flight_novld", 64'(cnt), 64'd0);
        issue(mk(4'h1, 4'd9, 4'd7, 4'd1, 16'd0));
        expect_retire("rf_zero_a", 32'd0, 1'b1, 4'd9, 1'b0);
        issue(mk(4'h1, 4'd10, 4'd8, 4'd2, 16'd0));
        expect_retire("rf_zero_b", 32'd0, 1'b1, 4'd10, 1'b0);

        // Reset while a MUL is iterating.
        issue(mk(4'h9, 4'd1, 4'd0, 4'd0, 16'd3));
        issue(mk(4'hC, 4'd4, 4'd1, 4'd1, 16'd0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle_outputs("rst_mul");
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (result_valid) cnt++;
        end
        chk("rst_mul_novld", 64'(cnt), 64'd0);
        chk("rst_mul_rdy", 64'(in_ready), 64'd1);
        issue(mk(4'h1, 4'd11, 4'd1, 4'd4, 16'd0));
        expect_retire("rst_mul_rf", 32'd0, 1'b1, 4'd11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
